// File: rtl/ahb_apb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_apb_pkg
// Shared definitions for the AHB-to-APB multi-slave bridge: the bridge state
// encoding, AHB HTRANS / HRESP codes and a helper that classifies HTRANS.
// No ports (package).
// -----------------------------------------------------------------------------
package ahb_apb_pkg;

  // Bridge states, kept as plain localparam constants for legacy tools
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WDATA  = 3'd1;
  localparam state_t ST_SETUP  = 3'd2;
  localparam state_t ST_ACCESS = 3'd3;
  localparam state_t ST_ERR1   = 3'd4;
  localparam state_t ST_ERR2   = 3'd5;

  // AHB transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB responses
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // APB / AHB data width
  localparam int PDATA_W = 32;

  // True for the transfer types that request a real data phase
  function automatic logic is_active_trans(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/apb_slot_mux.sv
// -----------------------------------------------------------------------------
// apb_slot_mux
// Decodes a slave-slot number into a one-hot APB select and steers the
// addressed slave's PRDATA / PREADY / PSLVERR back to the bridge.
// Ports:
//   i_slot     slot number under decode
//   i_prdata   packed read data, slave k at [32k+31:32k]
//   i_pready   per-slave ready
//   i_pslverr  per-slave error
//   o_mapped   slot addresses an existing slave
//   o_onehot   one-hot select for the slot (all zero when unmapped)
//   o_prdata, o_pready, o_pslverr  the addressed slave's response (zero when unmapped)
// -----------------------------------------------------------------------------
module apb_slot_mux
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SLOT_W  = 4
) (
  input  logic [SLOT_W-1:0]          i_slot,
  input  logic [PDATA_W*NUM_SLV-1:0] i_prdata,
  input  logic [NUM_SLV-1:0]         i_pready,
  input  logic [NUM_SLV-1:0]         i_pslverr,
  output logic                       o_mapped,
  output logic [NUM_SLV-1:0]         o_onehot,
  output logic [PDATA_W-1:0]         o_prdata,
  output logic                       o_pready,
  output logic                       o_pslverr
);

  // Compare the slot against every slave index; only a match contributes
  always_comb begin
    o_mapped  = 1'b0;
    o_onehot  = '0;
    o_prdata  = '0;
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (i_slot == SLOT_W'(k)) begin
        o_mapped    = 1'b1;
        o_onehot[k] = 1'b1;
        o_prdata    = i_prdata[PDATA_W*k +: PDATA_W];
        o_pready    = i_pready[k];
        o_pslverr   = i_pslverr[k];
      end else begin
        o_onehot[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb2apb_multi_bridge.sv
// -----------------------------------------------------------------------------
// ahb2apb_multi_bridge
// AHB slave to multi-slave APB bridge. One AHB transfer at a time is turned
// into an APB SETUP/ACCESS pair on the slave chosen by the address slot field
// HADDR[PADDR_W-1:SEL_LSB]. Unmapped slots, PSLVERR and ACCESS timeouts give
// the two-cycle AHB ERROR response. All bus outputs are registered.
// Ports:
//   iClk, iRsn                      clock, synchronous active-high reset
//   iHSEL, iHADDR, iHTRANS, iHWRITE, iHREADYin, iHWDATA   AHB inputs
//   oHRDATA, oHREADYout, oHRESP     AHB outputs
//   oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA              APB outputs
//   iPRDATA, iPREADY, iPSLVERR      APB per-slave returns
// -----------------------------------------------------------------------------
module ahb2apb_multi_bridge
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int PADDR_W = 16,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                       iClk,
  input  logic                       iRsn,
  input  logic                       iHSEL,
  input  logic [31:0]                iHADDR,
  input  logic [1:0]                 iHTRANS,
  input  logic                       iHWRITE,
  input  logic                       iHREADYin,
  input  logic [31:0]                iHWDATA,
  output logic [31:0]                oHRDATA,
  output logic                       oHREADYout,
  output logic [1:0]                 oHRESP,
  output logic [NUM_SLV-1:0]         oPSEL,
  output logic                       oPENABLE,
  output logic                       oPWRITE,
  output logic [PADDR_W-1:0]         oPADDR,
  output logic [31:0]                oPWDATA,
  input  logic [PDATA_W*NUM_SLV-1:0] iPRDATA,
  input  logic [NUM_SLV-1:0]         iPREADY,
  input  logic [NUM_SLV-1:0]         iPSLVERR
);

  localparam int          SLOT_W     = PADDR_W - SEL_LSB;
  localparam logic [16:0] TIMEOUT_L  = 17'(TIMEOUT);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_SLV-1:0]   r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [PADDR_W-1:0]   r_paddr;
  logic [31:0]          r_pwdata;
  logic [31:0]          r_hrdata;
  logic                 r_hready;
  logic [1:0]           r_hresp;
  logic [15:0]          r_wait_cnt;

  logic                 w_accept;
  logic [SLOT_W-1:0]    w_slot_nxt;
  logic                 w_mapped;
  logic [NUM_SLV-1:0]   w_onehot;
  logic [31:0]          w_prdata;
  logic                 w_pready;
  logic                 w_pslverr;
  logic                 w_timeout_hit;
  logic [31:0]          w_unused_haddr;

  // HADDR bits above the APB address width are intentionally dropped
  assign w_unused_haddr = iHADDR;

  // New transfers are only taken while the bridge is driving HREADYout high
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_ERR2)) &&
                    iHSEL && iHREADYin && is_active_trans(iHTRANS);

  // The slot of the transfer about to own the APB bus: the incoming one on
  // acceptance, otherwise the one already captured in the address register
  assign w_slot_nxt = w_accept ? iHADDR[PADDR_W-1:SEL_LSB] : r_paddr[PADDR_W-1:SEL_LSB];

  // Counter is one short of TIMEOUT on the final permitted stalled cycle
  assign w_timeout_hit = TIMEOUT_EN && (({1'b0, r_wait_cnt} + 17'd1) == TIMEOUT_L);

  apb_slot_mux #(
    .NUM_SLV (NUM_SLV),
    .SLOT_W  (SLOT_W)
  ) u_slot_mux (
    .i_slot    (w_slot_nxt),
    .i_prdata  (iPRDATA),
    .i_pready  (iPREADY),
    .i_pslverr (iPSLVERR),
    .o_mapped  (w_mapped),
    .o_onehot  (w_onehot),
    .o_prdata  (w_prdata),
    .o_pready  (w_pready),
    .o_pslverr (w_pslverr)
  );

  // Next-state decision for the bridge sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (w_accept) begin
          if (!w_mapped) begin
            w_state_nxt = ST_ERR1;
          end else if (iHWRITE) begin
            w_state_nxt = ST_WDATA;
          end else begin
            w_state_nxt = ST_SETUP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WDATA:  w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (w_pready) begin
          w_state_nxt = w_pslverr ? ST_ERR1 : ST_IDLE;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_ERR1;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ERR1:   w_state_nxt = ST_ERR2;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the AHB handshake outputs, derived from the next state
  // so that they appear registered in the same cycle the state takes effect
  always_ff @(posedge iClk) begin
    if (iRsn) begin
      r_state  <= ST_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
    end else begin
      r_state  <= w_state_nxt;
      r_hready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERR2);
      r_hresp  <= ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ?
                  HRESP_ERROR : HRESP_OKAY;
    end
  end

  // APB select/enable follow the next state; an abort drops both at once
  always_ff @(posedge iClk) begin
    if (iRsn) begin
      r_psel    <= '0;
      r_penable <= 1'b0;
    end else begin
      r_psel    <= ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS)) ? w_onehot : '0;
      r_penable <= (w_state_nxt == ST_ACCESS);
    end
  end

  // Address-phase capture and write-data capture during the one WDATA cycle
  always_ff @(posedge iClk) begin
    if (iRsn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= iHADDR[PADDR_W-1:0];
        r_pwrite <= iHWRITE;
      end
      if (r_state == ST_WDATA) begin
        r_pwdata <= iHWDATA;
      end
    end
  end

  // Read data only updates on an error-free read completion
  always_ff @(posedge iClk) begin
    if (iRsn) begin
      r_hrdata <= '0;
    end else if ((r_state == ST_ACCESS) && w_pready && !w_pslverr && !r_pwrite) begin
      r_hrdata <= w_prdata;
    end
  end

  // ACCESS wait counter: cleared entering SETUP, counts stalled ACCESS cycles
  always_ff @(posedge iClk) begin
    if (iRsn) begin
      r_wait_cnt <= 16'd0;
    end else if (w_state_nxt == ST_SETUP) begin
      r_wait_cnt <= 16'd0;
    end else if ((r_state == ST_ACCESS) && !w_pready) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign oHRDATA    = r_hrdata;
  assign oHREADYout = r_hready;
  assign oHRESP     = r_hresp;
  assign oPSEL      = r_psel;
  assign oPENABLE   = r_penable;
  assign oPWRITE    = r_pwrite;
  assign oPADDR     = r_paddr;
  assign oPWDATA    = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_multi_bridge.sv
// -----------------------------------------------------------------------------
// tb_ahb2apb_multi_bridge
// Directed and randomized transfers against a transaction-level expectation of
// the bridge: each transfer's cycle-by-cycle bus picture is derived from its
// kind (read/write, mapped/unmapped, wait count, slave error, timeout).
// -----------------------------------------------------------------------------
module tb_ahb2apb_multi_bridge;

  localparam int NSLV = 4;
  localparam int TO   = 8;

  logic              iClk = 1'b0;
  logic              iRsn;
  logic              iHSEL;
  logic [31:0]       iHADDR;
  logic [1:0]        iHTRANS;
  logic              iHWRITE;
  logic              iHREADYin;
  logic [31:0]       iHWDATA;
  logic [31:0]       oHRDATA;
  logic              oHREADYout;
  logic [1:0]        oHRESP;
  logic [NSLV-1:0]   oPSEL;
  logic              oPENABLE;
  logic              oPWRITE;
  logic [15:0]       oPADDR;
  logic [31:0]       oPWDATA;
  logic [32*NSLV-1:0] iPRDATA;
  logic [NSLV-1:0]   iPREADY;
  logic [NSLV-1:0]   iPSLVERR;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hrdata = 32'd0;

  ahb2apb_multi_bridge #(
    .NUM_SLV (NSLV),
    .PADDR_W (16),
    .SEL_LSB (12),
    .TIMEOUT (TO)
  ) dut (
    .iClk       (iClk),
    .iRsn       (iRsn),
    .iHSEL      (iHSEL),
    .iHADDR     (iHADDR),
    .iHTRANS    (iHTRANS),
    .iHWRITE    (iHWRITE),
    .iHREADYin  (iHREADYin),
    .iHWDATA    (iHWDATA),
    .oHRDATA    (oHRDATA),
    .oHREADYout (oHREADYout),
    .oHRESP     (oHRESP),
    .oPSEL      (oPSEL),
    .oPENABLE   (oPENABLE),
    .oPWRITE    (oPWRITE),
    .oPADDR     (oPADDR),
    .oPWDATA    (oPWDATA),
    .iPRDATA    (iPRDATA),
    .iPREADY    (iPREADY),
    .iPSLVERR   (iPSLVERR)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [3:0] psel, input logic pen,
                           input logic hrdy, input logic [1:0] resp);
    check({tag, "_psel"},   32'(oPSEL),      32'(psel));
    check({tag, "_pen"},    32'(oPENABLE),   32'(pen));
    check({tag, "_hready"}, 32'(oHREADYout), 32'(hrdy));
    check({tag, "_hresp"},  32'(oHRESP),     32'(resp));
  endtask

  // Random traffic on every slave; slot s (if in range) gets the given values
  task automatic drive_slaves(input int s, input logic rdy, input logic err, input logic [31:0] data);
    iPREADY  = 4'($urandom);
    iPSLVERR = 4'($urandom);
    for (int k = 0; k < NSLV; k++) iPRDATA[32*k +: 32] = $urandom;
    if (s >= 0 && s < NSLV) begin
      iPREADY[s]           = rdy;
      iPSLVERR[s]          = err;
      iPRDATA[32*s +: 32]  = data;
    end
  endtask

  // Two-cycle ERROR tail; leaves the bench in the ERR2 cycle
  task automatic err_tail(input string tag);
    check_bus({tag, "_err1"}, 4'd0, 1'b0, 1'b0, 2'b01);
    check({tag, "_err1_hrdata"}, oHRDATA, exp_hrdata);
    drive_slaves(-1, 1'b0, 1'b0, 32'd0);
    tick();
    check_bus({tag, "_err2"}, 4'd0, 1'b0, 1'b1, 2'b01);
  endtask

  // One complete AHB transfer; must start in a cycle with HREADYout high
  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input int waits, input logic err,
                      input logic [31:0] rdata);
    int   s;
    bit   tmo;
    int   n_acc;
    logic [3:0] oh;
    s     = int'(addr[15:12]);
    tmo   = (waits >= TO);
    n_acc = tmo ? TO : waits + 1;
    oh    = 4'd1 << s;
    check({tag, "_addr_hready"}, 32'(oHREADYout), 32'd1);
    iHSEL     = 1'b1;
    iHTRANS   = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    iHADDR    = addr;
    iHWRITE   = wr;
    iHREADYin = 1'b1;
    drive_slaves(-1, 1'b0, 1'b0, 32'd0);
    tick();
    iHSEL   = 1'b0;
    iHTRANS = 2'b00;
    iHADDR  = $urandom;
    iHWRITE = 1'($urandom);
    iHWDATA = wdata;
    if (s >= NSLV) begin
      err_tail({tag, "_unm"});
    end else begin
      if (wr) begin
        check_bus({tag, "_wdata"}, 4'd0, 1'b0, 1'b0, 2'b00);
        drive_slaves(-1, 1'b0, 1'b0, 32'd0);
        tick();
        iHWDATA = $urandom;
      end
      check_bus({tag, "_setup"}, oh, 1'b0, 1'b0, 2'b00);
      check({tag, "_setup_paddr"},  32'(oPADDR),  32'(addr[15:0]));
      check({tag, "_setup_pwrite"}, 32'(oPWRITE), 32'(wr));
      if (wr) check({tag, "_setup_pwdata"}, oPWDATA, wdata);
      drive_slaves(-1, 1'b0, 1'b0, 32'd0);
      tick();
      for (int a = 0; a < n_acc; a++) begin
        check_bus({tag, "_access"}, oh, 1'b1, 1'b0, 2'b00);
        check({tag, "_access_paddr"}, 32'(oPADDR), 32'(addr[15:0]));
        if (wr) check({tag, "_access_pwdata"}, oPWDATA, wdata);
        check({tag, "_access_hrdata"}, oHRDATA, exp_hrdata);
        if (!tmo && a == waits) drive_slaves(s, 1'b1, err, rdata);
        else                    drive_slaves(s, 1'b0, 1'($urandom), $urandom);
        tick();
      end
      if (tmo || err) begin
        err_tail(tag);
      end else begin
        if (!wr) exp_hrdata = rdata;
        check_bus({tag, "_done"}, 4'd0, 1'b0, 1'b1, 2'b00);
        check({tag, "_done_hrdata"}, oHRDATA, exp_hrdata);
      end
    end
  endtask

  initial begin
    logic [31:0] ra;
    iRsn = 1'b1; iHSEL = 1'b0; iHADDR = 32'd0; iHTRANS = 2'b00; iHWRITE = 1'b0;
    iHREADYin = 1'b1; iHWDATA = 32'd0; iPRDATA = '0; iPREADY = '0; iPSLVERR = '0;
    tick(); tick();
    check_bus("reset", 4'd0, 1'b0, 1'b1, 2'b00);
    check("reset_hrdata", oHRDATA, 32'd0);
    check("reset_paddr",  32'(oPADDR), 32'd0);
    iRsn = 1'b0;
    tick();

    // Read slave 1, ready in the first ACCESS cycle
    xfer("rd_s1", 32'h0000_1004, 1'b0, 32'd0, 0, 1'b0, 32'hCAFE_0001);
    // Write slave 3, five wait cycles
    xfer("wr_s3", 32'h0000_3010, 1'b1, 32'hA5A5_5A5A, 5, 1'b0, 32'd0);
    // Slave error on read of slave 2
    xfer("slverr", 32'h0000_2000, 1'b0, 32'd0, 1, 1'b1, 32'h1234_5678);
    // Unmapped slot 7, accepted from ERR2
    xfer("unmap", 32'h0000_7000, 1'b0, 32'd0, 0, 1'b0, 32'd0);
    // Slave 0 never ready: timeout after TO ACCESS cycles
    xfer("tmo", 32'h0000_0040, 1'b0, 32'd0, 50, 1'b0, 32'd0);
    iHSEL = 1'b0; iHTRANS = 2'b00;
    tick();
    check_bus("after_err", 4'd0, 1'b0, 1'b1, 2'b00);

    // IDLE / BUSY / not-ready transfers are not accepted
    iHSEL = 1'b1; iHADDR = 32'h0000_1000; iHWRITE = 1'b0; iHTRANS = 2'b01;
    tick();
    check_bus("busy", 4'd0, 1'b0, 1'b1, 2'b00);
    iHTRANS = 2'b10; iHREADYin = 1'b0;
    tick();
    check_bus("nordy", 4'd0, 1'b0, 1'b1, 2'b00);
    iHTRANS = 2'b00; iHREADYin = 1'b1;
    tick();
    check_bus("htidle", 4'd0, 1'b0, 1'b1, 2'b00);
    iHSEL = 1'b0;

    // Reset in the third ACCESS cycle of a stalled write
    iHSEL = 1'b1; iHTRANS = 2'b10; iHADDR = 32'h0000_2010; iHWRITE = 1'b1;
    drive_slaves(2, 1'b0, 1'b0, 32'd0);
    tick();
    iHSEL = 1'b0; iHTRANS = 2'b00; iHWDATA = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      drive_slaves(2, 1'b0, 1'b0, 32'd0);
      tick();
    end
    check("rst_pre_pen", 32'(oPENABLE), 32'd1);
    iRsn = 1'b1;
    tick();
    check_bus("rst_mid", 4'd0, 1'b0, 1'b1, 2'b00);
    check("rst_mid_pwrite", 32'(oPWRITE), 32'd0);
    check("rst_mid_paddr",  32'(oPADDR),  32'd0);
    check("rst_mid_pwdata", oPWDATA, 32'd0);
    check("rst_mid_hrdata", oHRDATA, 32'd0);
    exp_hrdata = 32'd0;
    iRsn = 1'b0;
    drive_slaves(2, 1'b1, 1'b0, 32'd0);
    tick();
    check_bus("rst_after", 4'd0, 1'b0, 1'b1, 2'b00);

    // Back-to-back read then write
    xfer("b2b_rd", 32'h0000_1100, 1'b0, 32'd0, 0, 1'b0, 32'h0BAD_F00D);
    xfer("b2b_wr", 32'h0000_3200, 1'b1, 32'h1357_9BDF, 0, 1'b0, 32'd0);

    // Randomized transfers, including unmapped slots and timeouts
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      ra[15:12] = 4'($urandom_range(0, 5));
      xfer("rnd", ra, 1'($urandom), $urandom, $urandom_range(0, 9),
           ($urandom_range(0, 4) == 0), $urandom);
    end
    iHSEL = 1'b0; iHTRANS = 2'b00;
    tick();
    check_bus("final", 4'd0, 1'b0, 1'b1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
